// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves memory waits, multicycle EX ops, taken branches and load-use
// hazards, in that priority, and drives PC / stage register enables and
// bubble-insert flushes. Also counts stall cycles (saturating).
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_r1,
    input  logic [4:0]  id_r2,
    input  logic        id_uses_r2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_is_mul,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        s1_en,
    output logic        s2_en,
    output logic        s3_en,
    output logic        s4_en,
    output logic        s1_flush,
    output logic        s2_flush,
    output logic        s3_flush,
    output logic        busy,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MUL_WAIT} state_t;

    // A single-cycle multiplier never needs to freeze the front end.
    localparam bit         MUL_STALL = (MUL_CYCLES >= 2);
    localparam logic [3:0] MUL_INIT  = 4'(MUL_STALL ? MUL_CYCLES - 2 : 0);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       lu;
    logic       run_eval;
    logic       mem_block;

    // Load-use: the loaded value is not available until after MEM.
    assign lu = ex_is_load && (ex_rd != 5'd0) &&
                ((ex_rd == id_r1) || (id_uses_r2 && (ex_rd == id_r2)));

    assign busy = (state != RUN);

    // Next-state and enable/flush decode; reset forces every enable low.
    always_comb begin
        pc_en     = 1'b1;
        s1_en     = 1'b1;
        s2_en     = 1'b1;
        s3_en     = 1'b1;
        s4_en     = 1'b1;
        s1_flush  = 1'b0;
        s2_flush  = 1'b0;
        s3_flush  = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        run_eval  = 1'b0;
        mem_block = 1'b0;

        case (state)
            RUN: begin
                run_eval  = 1'b1;
                mem_block = mem_req && !mem_ack;
            end
            MEM_WAIT: begin
                if (!mem_ack) begin
                    {pc_en, s1_en, s2_en, s3_en, s4_en} = 5'b00000;
                end else begin
                    // Ack cycle behaves like RUN with the memory satisfied.
                    run_eval = 1'b1;
                end
            end
            MUL_WAIT: begin
                if (cnt != 4'd0) begin
                    {pc_en, s1_en, s2_en} = 3'b000;
                    s3_flush = 1'b1;
                    cnt_nxt  = cnt - 4'd1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (run_eval) begin
            state_nxt = RUN;
            if (mem_block) begin
                {pc_en, s1_en, s2_en, s3_en, s4_en} = 5'b00000;
                state_nxt = MEM_WAIT;
            end else if (ex_is_mul && MUL_STALL) begin
                {pc_en, s1_en, s2_en} = 3'b000;
                s3_flush  = 1'b1;
                cnt_nxt   = MUL_INIT;
                state_nxt = MUL_WAIT;
            end else if (ex_branch_taken) begin
                s1_flush = 1'b1;
                s2_flush = 1'b1;
            end else if (lu) begin
                {pc_en, s1_en} = 2'b00;
                s2_flush = 1'b1;
            end
        end

        if (rst) begin
            {pc_en, s1_en, s2_en, s3_en, s4_en} = 5'b00000;
            {s1_flush, s2_flush, s3_flush}      = 3'b000;
        end
    end

    // FSM state and multicycle countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 16'd0;
        end else if (!pc_en && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table walked cycle by cycle
// plus hand sequences for mem-wait into mul, reset mid-stall and saturation.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_r1, id_r2, ex_rd;
    logic        id_uses_r2, ex_is_load, ex_is_mul, ex_branch_taken;
    logic        mem_req, mem_ack;

    logic        pc_en, s1_en, s2_en, s3_en, s4_en, s1_flush, s2_flush, s3_flush, busy;
    logic [15:0] stall_count;
    logic        pc_en1, s1_en1, s2_en1, s3_en1, s4_en1, s1_flush1, s2_flush1, s3_flush1, busy1;
    logic [15:0] stall_count1;

    logic [7:0]  o, o1;
    assign o  = {pc_en, s1_en, s2_en, s3_en, s4_en, s1_flush, s2_flush, s3_flush};
    assign o1 = {pc_en1, s1_en1, s2_en1, s3_en1, s4_en1, s1_flush1, s2_flush1, s3_flush1};

    // {pc_en, s1_en, s2_en, s3_en, s4_en, s1_flush, s2_flush, s3_flush}
    localparam logic [7:0] ADV  = 8'b11111_000;
    localparam logic [7:0] FRZ  = 8'b00000_000;
    localparam logic [7:0] MULS = 8'b00011_001;
    localparam logic [7:0] LUS  = 8'b00111_010;
    localparam logic [7:0] BR   = 8'b11111_110;

    pipe_hazard_ctrl #(.MUL_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .id_r1(id_r1), .id_r2(id_r2), .id_uses_r2(id_uses_r2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .s1_en(s1_en), .s2_en(s2_en), .s3_en(s3_en), .s4_en(s4_en),
        .s1_flush(s1_flush), .s2_flush(s2_flush), .s3_flush(s3_flush),
        .busy(busy), .stall_count(stall_count)
    );

    pipe_hazard_ctrl #(.MUL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_r1(id_r1), .id_r2(id_r2), .id_uses_r2(id_uses_r2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en1), .s1_en(s1_en1), .s2_en(s2_en1), .s3_en(s3_en1), .s4_en(s4_en1),
        .s1_flush(s1_flush1), .s2_flush(s2_flush1), .s3_flush(s3_flush1),
        .busy(busy1), .stall_count(stall_count1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  r1, r2, rd;
        logic        u2, ld, mul, br, req, ack;
        logic [7:0]  eo;
        logic        eb;
        logic [15:0] esc;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                                input logic [4:0] rd, input logic ld, input logic mul,
                                input logic br, input logic req, input logic ack,
                                input logic [7:0] eo, input logic eb, input logic [15:0] esc);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.u2 = u2; v.rd = rd; v.ld = ld; v.mul = mul;
        v.br = br; v.req = req; v.ack = ack; v.eo = eo; v.eb = eb; v.esc = esc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_r1 = v.r1; id_r2 = v.r2; id_uses_r2 = v.u2; ex_rd = v.rd;
        ex_is_load = v.ld; ex_is_mul = v.mul; ex_branch_taken = v.br;
        mem_req = v.req; mem_ack = v.ack;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 0, 0));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[24];

    initial begin
        //             r1 r2 u2 rd ld mul br req ack  out   busy sc
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  0, 0);   // idle
        tbl[1]  = mk(5, 0, 0, 5, 1, 0, 0, 0, 0, LUS,  0, 0);   // LU on rs1
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  0, 1);   // single stall only
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, ADV,  0, 1);   // rd=x0 never hazards
        tbl[4]  = mk(1, 7, 0, 7, 1, 0, 0, 0, 0, ADV,  0, 1);   // rs2 unused
        tbl[5]  = mk(1, 7, 1, 7, 1, 0, 0, 0, 0, LUS,  0, 1);   // LU on rs2
        tbl[6]  = mk(5, 0, 0, 5, 1, 0, 1, 0, 0, BR,   0, 2);   // branch beats LU
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  0, 2);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, MULS, 0, 2);   // mul enters
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, MULS, 1, 3);   // cnt=2
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, MULS, 1, 4);   // cnt=1
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, ADV,  1, 5);   // cnt=0 advance
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  0, 5);
        tbl[13] = mk(3, 0, 0, 3, 1, 0, 0, 1, 1, LUS,  0, 5);   // same-cycle ack no wait
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  0, 6);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ,  0, 6);   // mem beats mul
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  1, 7);   // still waiting
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, BR,   1, 8);   // ack honours branch
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  0, 8);
        tbl[19] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, MULS, 0, 8);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MULS, 1, 9);   // mem ignored in MUL_WAIT
        tbl[21] = mk(5, 0, 0, 5, 1, 0, 1, 0, 0, MULS, 1, 10);  // br/LU ignored
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  1, 11);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  0, 11);

        // Reset state
        rst = 1'b1;
        idle();
        ex_branch_taken = 1'b1;
        #2;
        chk("rst_out", 32'(o), 32'(FRZ));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sc", 32'(stall_count), 0);
        next_cycle();
        rst = 1'b0;
        idle();

        // Table walk
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d_out", i), 32'(o), 32'(tbl[i].eo));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("v%0d_sc", i), 32'(stall_count), 32'(tbl[i].esc));
            next_cycle();
        end

        // Memory wait with mul behind it; MUL_CYCLES=1 instance advances on ack
        drive(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mw_frz%0d", i), 32'(o), 32'(FRZ));
            chk($sformatf("mw1_frz%0d", i), 32'(o1), 32'(FRZ));
            next_cycle();
        end
        mem_ack = 1'b1;
        @(negedge clk);
        chk("mw_ack_mul", 32'(o), 32'(MULS));
        chk("mw1_ack_adv", 32'(o1), 32'(ADV));
        next_cycle();
        idle();
        @(negedge clk);
        chk("mw_busy_mul", 32'(busy), 1);
        chk("mw1_busy", 32'(busy1), 0);
        chk("mw_mul_c2", 32'(o), 32'(MULS));
        chk("mw1_idle", 32'(o1), 32'(ADV));
        next_cycle();
        @(negedge clk);
        chk("mw_mul_c1", 32'(o), 32'(MULS));
        next_cycle();
        @(negedge clk);
        chk("mw_mul_c0", 32'(o), 32'(ADV));
        next_cycle();
        @(negedge clk);
        chk("mw_sc", 32'(stall_count), 17);
        chk("mw_busy_end", 32'(busy), 0);
        next_cycle();

        // Asynchronous reset in MUL_WAIT with cnt=2
        ex_is_mul = 1'b1;
        @(negedge clk);
        chk("rm_enter", 32'(o), 32'(MULS));
        next_cycle();
        ex_branch_taken = 1'b1;
        rst = 1'b1;
        #1;
        chk("rm_out", 32'(o), 32'(FRZ));
        chk("rm_busy", 32'(busy), 0);
        chk("rm_sc", 32'(stall_count), 0);
        next_cycle();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rm_rel_out", 32'(o), 32'(ADV));
        chk("rm_rel_busy", 32'(busy), 0);
        next_cycle();
        @(negedge clk);
        chk("rm_rel_out2", 32'(o), 32'(ADV));
        chk("rm_rel_sc", 32'(stall_count), 0);
        next_cycle();

        // Saturation of stall_count under a long memory wait
        mem_req = 1'b1;
        mem_ack = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_sc", 32'(stall_count), 32'hFFFF);
        chk("sat_out", 32'(o), 32'(FRZ));
        chk("sat_busy", 32'(busy), 1);
        next_cycle();
        chk("sat_hold", 32'(stall_count), 32'hFFFF);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("sat_ack", 32'(o), 32'(ADV));
        next_cycle();
        idle();
        @(negedge clk);
        chk("sat_end_sc", 32'(stall_count), 32'hFFFF);
        chk("sat_end_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
